// File: rtl/ppr_sequencer.sv
// Post-package-repair sequencer: turns one arbitrated repair request into the
// MRS_ENTER / ACT / PRE / MRS_EXIT command sequence with timed waits between commands.
//
// state    | meaning
// IDLE     | ready for a request
// ENTER    | issue MRS_ENTER
// WAIT_MOD | wait T_MOD after MRS_ENTER
// ACT      | issue ACT to the repair row
// WAIT_PGM | wait soft/hard program time
// PRE      | issue PRE
// WAIT_RP  | wait T_RP
// EXIT     | issue MRS_EXIT
// DONE     | one-cycle done/err pulse
module ppr_sequencer #(
    parameter int N_CH       = 32,
    parameter int ADDR_SIZE  = 24,
    parameter int T_MOD      = 4,
    parameter int T_PGM_SOFT = 8,
    parameter int T_PGM_HARD = 32,
    parameter int T_RP       = 3,
    parameter int CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [1:0]              req_type_i,
    input  logic [ADDR_SIZE-1:0]    req_addr_i,
    input  logic [$clog2(N_CH)-1:0] req_ch_i,
    output logic                    cmd_valid_o,
    input  logic                    cmd_ready_i,
    output logic [2:0]              cmd_code_o,
    output logic [1:0]              cmd_type_o,
    output logic [ADDR_SIZE-1:0]    cmd_addr_o,
    output logic [$clog2(N_CH)-1:0] cmd_ch_o,
    output logic                    ppr_done_o,
    output logic                    ppr_err_o,
    output logic                    busy_o,
    output logic [15:0]             ppr_cnt_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_ENTER, S_WAIT_MOD, S_ACT, S_WAIT_PGM, S_PRE, S_WAIT_RP, S_EXIT, S_DONE
    } state_t;

    // Counters load T-1 so each wait state lasts exactly T cycles.
    localparam logic [CNT_W-1:0] LD_MOD  = CNT_W'(T_MOD - 1);
    localparam logic [CNT_W-1:0] LD_SOFT = CNT_W'(T_PGM_SOFT - 1);
    localparam logic [CNT_W-1:0] LD_HARD = CNT_W'(T_PGM_HARD - 1);
    localparam logic [CNT_W-1:0] LD_RP   = CNT_W'(T_RP - 1);

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [1:0]                type_q;
    logic [ADDR_SIZE-1:0]      addr_q;
    logic [$clog2(N_CH)-1:0]   ch_q;
    logic                      err_q;
    logic [15:0]               ppr_cnt_q;
    logic                      type_ok;

    assign type_ok = (req_type_i == 2'b01) || (req_type_i == 2'b10);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            type_q    <= '0;
            addr_q    <= '0;
            ch_q      <= '0;
            err_q     <= 1'b0;
            ppr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && req_valid_i) begin
                type_q <= req_type_i;
                addr_q <= req_addr_i;
                ch_q   <= req_ch_i;
                err_q  <= !type_ok;
            end
            if (state_q == S_DONE && !err_q && ppr_cnt_q != 16'hFFFF) begin
                ppr_cnt_q <= ppr_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_o = 1'b0;
        cmd_valid_o = 1'b0;
        cmd_code_o  = 3'd0;
        ppr_done_o  = 1'b0;
        ppr_err_o   = 1'b0;
        busy_o      = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy_o      = 1'b0;
                req_ready_o = 1'b1;
                if (req_valid_i) state_d = type_ok ? S_ENTER : S_DONE;
            end
            S_ENTER: begin
                cmd_valid_o = 1'b1;
                cmd_code_o  = 3'd1;
                if (cmd_ready_i) begin
                    state_d = S_WAIT_MOD;
                    cnt_d   = LD_MOD;
                end
            end
            S_WAIT_MOD: begin
                if (cnt_q == '0) state_d = S_ACT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_ACT: begin
                cmd_valid_o = 1'b1;
                cmd_code_o  = 3'd2;
                if (cmd_ready_i) begin
                    state_d = S_WAIT_PGM;
                    cnt_d   = (type_q == 2'b10) ? LD_HARD : LD_SOFT;
                end
            end
            S_WAIT_PGM: begin
                if (cnt_q == '0) state_d = S_PRE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_PRE: begin
                cmd_valid_o = 1'b1;
                cmd_code_o  = 3'd3;
                if (cmd_ready_i) begin
                    state_d = S_WAIT_RP;
                    cnt_d   = LD_RP;
                end
            end
            S_WAIT_RP: begin
                if (cnt_q == '0) state_d = S_EXIT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_EXIT: begin
                cmd_valid_o = 1'b1;
                cmd_code_o  = 3'd4;
                if (cmd_ready_i) state_d = S_DONE;
            end
            S_DONE: begin
                ppr_done_o = 1'b1;
                ppr_err_o  = err_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_type_o = type_q;
    assign cmd_addr_o = addr_q;
    assign cmd_ch_o   = ch_q;
    assign ppr_cnt_o  = ppr_cnt_q;

endmodule

// File: tb/tb_ppr_sequencer.sv
// Bench for ppr_sequencer: table-driven repair requests checked against a
// scoreboard of expected command handshakes and done pulses.
module tb_ppr_sequencer;

    localparam int T_MOD      = 4;
    localparam int T_PGM_SOFT = 8;
    localparam int T_PGM_HARD = 32;
    localparam int T_RP       = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [1:0]  req_type_i = 2'b00;
    logic [23:0] req_addr_i = '0;
    logic [4:0]  req_ch_i = '0;
    logic        cmd_valid_o;
    logic        cmd_ready_i = 1'b1;
    logic [2:0]  cmd_code_o;
    logic [1:0]  cmd_type_o;
    logic [23:0] cmd_addr_o;
    logic [4:0]  cmd_ch_o;
    logic        ppr_done_o;
    logic        ppr_err_o;
    logic        busy_o;
    logic [15:0] ppr_cnt_o;

    ppr_sequencer #(
        .N_CH(32), .ADDR_SIZE(24), .T_MOD(T_MOD), .T_PGM_SOFT(T_PGM_SOFT),
        .T_PGM_HARD(T_PGM_HARD), .T_RP(T_RP), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_type_i(req_type_i), .req_addr_i(req_addr_i), .req_ch_i(req_ch_i),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_code_o(cmd_code_o),
        .cmd_type_o(cmd_type_o), .cmd_addr_o(cmd_addr_o), .cmd_ch_o(cmd_ch_o),
        .ppr_done_o(ppr_done_o), .ppr_err_o(ppr_err_o), .busy_o(busy_o),
        .ppr_cnt_o(ppr_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  typ;
        logic [23:0] addr;
        logic [4:0]  ch;
        int          stall;
        int          exp_done;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [2:0]  code;
        logic [1:0]  typ;
        logic [23:0] addr;
        logic [4:0]  ch;
        int          hs;
    } cmd_exp_t;

    typedef struct {
        int   rel;
        logic err;
    } done_exp_t;

    cmd_exp_t  exp_q[$];
    done_exp_t done_q[$];
    vec_t      vecs[7];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t0 = 0;
    int stall_left = 0;
    int busy_cnt = 0;
    int exp_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Expected handshake cycles, relative to the request acceptance cycle.
    task automatic push_expect(input logic [1:0] typ, input logic [23:0] addr,
                               input logic [4:0] ch, input int stall,
                               input int done_rel, input logic err);
        int a, p, x, tpgm;
        if (typ == 2'b01 || typ == 2'b10) begin
            tpgm = (typ == 2'b10) ? T_PGM_HARD : T_PGM_SOFT;
            a = 1 + T_MOD + 1 + stall;
            p = a + tpgm + 1;
            x = p + T_RP + 1;
            exp_q.push_back('{3'd1, typ, addr, ch, 1});
            exp_q.push_back('{3'd2, typ, addr, ch, a});
            exp_q.push_back('{3'd3, typ, addr, ch, p});
            exp_q.push_back('{3'd4, typ, addr, ch, x});
        end
        done_q.push_back('{done_rel, err});
    endtask

    initial begin : monitor
        cmd_exp_t  e;
        done_exp_t d;
        forever begin
            @(negedge clk);
            if (cmd_valid_o && cmd_code_o == 3'd2 && stall_left > 0) begin
                cmd_ready_i = 1'b0;
                stall_left--;
            end else begin
                cmd_ready_i = 1'b1;
            end
            if (busy_o) busy_cnt++;
            if (!cmd_valid_o && cmd_code_o != 3'd0) fail("code_without_valid");
            if (cmd_valid_o) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_cmd");
                end else begin
                    e = exp_q[0];
                    chk("cmd_code", 32'(cmd_code_o), 32'(e.code));
                    chk("cmd_addr", 32'(cmd_addr_o), 32'(e.addr));
                    chk("cmd_ch", 32'(cmd_ch_o), 32'(e.ch));
                    chk("cmd_type", 32'(cmd_type_o), 32'(e.typ));
                    if (cmd_ready_i) begin
                        chk("cmd_hs_cycle", 32'(cyc - t0), 32'(e.hs));
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (ppr_done_o || ppr_err_o) begin
                if (done_q.size() == 0) begin
                    fail("unexpected_done");
                end else begin
                    d = done_q.pop_front();
                    chk("done_flag", 32'(ppr_done_o), 32'd1);
                    chk("done_cycle", 32'(cyc - t0), 32'(d.rel));
                    chk("err_flag", 32'(ppr_err_o), 32'(d.err));
                end
            end
        end
    end

    task automatic send(input vec_t v);
        int n = 0;
        @(negedge clk);
        while (!req_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_before_send", 32'(req_ready_o), 32'd1);
        stall_left  = v.stall;
        push_expect(v.typ, v.addr, v.ch, v.stall, v.exp_done, v.exp_err);
        req_type_i  = v.typ;
        req_addr_i  = v.addr;
        req_ch_i    = v.ch;
        req_valid_i = 1'b1;
        t0 = cyc;
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("pending_after_timeout", 32'(exp_q.size() + done_q.size()), 32'd0);
        exp_q.delete();
        done_q.delete();
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        busy_cnt = 0;
        send(v);
        wait_done();
        if (!v.exp_err) exp_cnt++;
        chk("ppr_cnt", 32'(ppr_cnt_o), 32'(exp_cnt));
        chk("busy_cycles", 32'(busy_cnt), 32'(v.exp_done));
        chk("idle_ready", 32'(req_ready_o), 32'd1);
        chk("idle_busy", 32'(busy_o), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t v;
        int   n;
        vecs[0] = '{2'b01, 24'h000200, 5'd5,  0, 20, 1'b0};
        vecs[1] = '{2'b10, 24'h000200, 5'd5,  0, 44, 1'b0};
        vecs[2] = '{2'b01, 24'h000200, 5'd5,  3, 23, 1'b0};
        vecs[3] = '{2'b11, 24'h123456, 5'd7,  0, 1,  1'b1};
        vecs[4] = '{2'b00, 24'hABCDEF, 5'd31, 0, 1,  1'b1};
        vecs[5] = '{2'b10, 24'hFFFFFF, 5'd31, 2, 46, 1'b0};
        vecs[6] = '{2'b01, 24'h000001, 5'd0,  0, 20, 1'b0};

        #1;
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_valid", 32'(cmd_valid_o), 32'd0);
        chk("rst_code", 32'(cmd_code_o), 32'd0);
        chk("rst_done", 32'(ppr_done_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_cnt", 32'(ppr_cnt_o), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Back-to-back: valid held high across the whole first sequence.
        @(negedge clk);
        stall_left  = 0;
        push_expect(2'b01, 24'h000200, 5'd5, 0, 20, 1'b0);
        req_type_i  = 2'b01;
        req_addr_i  = 24'h000200;
        req_ch_i    = 5'd5;
        req_valid_i = 1'b1;
        t0 = cyc;
        @(negedge clk);
        req_type_i  = 2'b10;
        req_addr_i  = 24'h0ABCDE;
        req_ch_i    = 5'd17;
        chk("b2b_ready_low", 32'(req_ready_o), 32'd0);
        n = 0;
        while (!req_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_accept_cycle", 32'(cyc - t0), 32'd21);
        t0 = cyc;
        push_expect(2'b10, 24'h0ABCDE, 5'd17, 0, 44, 1'b0);
        @(negedge clk);
        req_valid_i = 1'b0;
        wait_done();
        exp_cnt += 2;
        chk("b2b_cnt", 32'(ppr_cnt_o), 32'(exp_cnt));

        // Reset in the middle of a hard-PPR program wait.
        v = '{2'b10, 24'h00F00D, 5'd9, 0, 44, 1'b0};
        send(v);
        n = 0;
        while ((cyc - t0) < 20 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("pgm_busy", 32'(busy_o), 32'd1);
        chk("pgm_no_cmd", 32'(cmd_valid_o), 32'd0);
        #1 rst = 1'b1;
        #1;
        exp_q.delete();
        done_q.delete();
        chk("mid_rst_ready", 32'(req_ready_o), 32'd1);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_valid", 32'(cmd_valid_o), 32'd0);
        chk("mid_rst_addr", 32'(cmd_addr_o), 32'd0);
        chk("mid_rst_ch", 32'(cmd_ch_o), 32'd0);
        chk("mid_rst_type", 32'(cmd_type_o), 32'd0);
        chk("mid_rst_cnt", 32'(ppr_cnt_o), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        repeat (50) @(negedge clk);
        chk("post_rst_idle", 32'(busy_o), 32'd0);
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ppr_sequencer.md
Name: ppr_sequencer

Overview:
- Responder end of the PPR request interface: accepts one arbitrated repair request (type, row address, channel) from the PPR arbiter.
- Expands each request into the DRAM post-package-repair command sequence: MRS_ENTER, ACT, PRE, MRS_EXIT, with parameterised waits between them.
- Returns a one-cycle done (and error) pulse to the arbiter.
- Sits between the PPR arbiter and the per-channel DRAM command scheduler.

Parameters:
- N_CH, 32, number of pseudo channels.
- ADDR_SIZE, 24, repair row address width.
- T_MOD, 4, cycles waited after MRS_ENTER (≥1).
- T_PGM_SOFT, 8, cycles waited after ACT for soft PPR (≥1).
- T_PGM_HARD, 32, cycles waited after ACT for hard PPR (≥1).
- T_RP, 3, cycles waited after PRE (≥1).
- CNT_W, 8, wait-counter width; must hold max(T_*).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_type_i  in  2  2'b01 soft PPR, 2'b10 hard PPR; 00/11 invalid.
- req_addr_i  in  ADDR_SIZE  row to repair.
- req_ch_i  in  $clog2(N_CH)  target channel.
- cmd_valid_o  out  1  DRAM command valid.
- cmd_ready_i  in  1  scheduler accepts command.
- cmd_code_o  out  3  1 MRS_ENTER, 2 ACT, 3 PRE, 4 MRS_EXIT, 0 idle.
- cmd_type_o  out  2  latched request type.
- cmd_addr_o  out  ADDR_SIZE  latched address.
- cmd_ch_o  out  $clog2(N_CH)  latched channel.
- ppr_done_o  out  1  one-cycle completion pulse.
- ppr_err_o  out  1  one-cycle pulse with done on an invalid type.
- busy_o  out  1  high in every state except IDLE.
- ppr_cnt_o  out  16  count of successful repairs; saturates at 16'hFFFF.

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, all latches=0, all outputs 0 except req_ready_o=1. No MRS_EXIT is issued for an interrupted sequence.
- States: IDLE, ENTER, WAIT_MOD, ACT, WAIT_PGM, PRE, WAIT_RP, EXIT, DONE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch type, addr and ch.
  - Next state is ENTER if type is 01 or 10, else DONE with the error flag set.
  - req_ready_o=0 in all other states; requests are never dropped, only stalled.
- Command states (ENTER, ACT, PRE, EXIT):
  - cmd_valid_o=1; cmd_code_o as listed; cmd_addr/ch/type_o driven from latches.
  - Hold until cmd_ready_i=1. Command fields stay stable while waiting.
  - On handshake, move to the next wait state and load counter=T-1.
  - After EXIT's handshake, go to DONE.
- Wait states:
  - cmd_valid_o=0.
  - Each wait state lasts exactly T cycles: decrement the counter each cycle and exit in the cycle it reads 0.
  - WAIT_PGM uses T_PGM_HARD when the latched type is 10, else T_PGM_SOFT.
  - Exits: WAIT_MOD→ACT, WAIT_PGM→PRE, WAIT_RP→EXIT.
- DONE: lasts 1 cycle.
  - ppr_done_o=1.
  - ppr_err_o=1 only for an invalid type.
  - ppr_cnt_o increments (saturating) when not in error.
  - Then return to IDLE; the next request can be accepted in the following cycle.
- Outputs are registered: cmd_* and done change only on clock edges.
- cmd_code_o=0 and cmd_valid_o=0 outside command states.

Test Plan:
- Soft PPR, cmd_ready_i tied 1, request (01, 24'h000200, ch 5) accepted at cycle 0:
  - ENTER at cycle 1, ACT at cycle 6, PRE at cycle 15, EXIT at cycle 19.
  - ppr_done_o=1 at cycle 20 only; ppr_cnt_o becomes 1; cmd_addr_o=24'h000200, cmd_ch_o=5 on every command.
- Hard PPR, same setup with type 10: ACT at cycle 6, PRE at cycle 39, EXIT at cycle 43, done at cycle 44; busy_o high cycles 1–44.
- Backpressure on a soft request: cmd_ready_i=0 for 3 cycles during ACT.
  - ACT is held with stable fields for 4 cycles, then accepted.
  - Every later event shifts by +3 (done at cycle 23).
- Invalid type 11: done and err pulse together at cycle 1, no cmd_valid_o ever, ppr_cnt_o unchanged.
- Back-to-back requests with req_valid_i held high:
  - The second request is not accepted (req_ready_o=0) until IDLE, i.e. the cycle after DONE.
  - The second sequence's ENTER follows 1 cycle after that acceptance.
- rst asserted mid-WAIT_PGM: all outputs zero immediately (req_ready_o=1), no EXIT issued; a fresh soft request then completes in 20 cycles.
